// File: rtl/video_pkg.sv
// Shared types and constants for the video timing / test-pattern generator.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // Colour-bar table as {r,g,b} on/off flags, entry 0 on the left of the screen:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  // Default 640x480@60 timing.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIX_SZ   = 4;
  localparam int DEF_BAR_W    = 80;

  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/video_timing.sv
// Pixel/line counters, sync and data-enable decode, frame-start pulse.
// The h/v counters are exported combinationally so the top level can build
// the pixel colour for the same position that the registered timing reflects.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HSZ     = $clog2(H_TOTAL),
  localparam int VSZ     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           ce,
  output logic [HSZ-1:0] h,
  output logic [VSZ-1:0] v,
  output logic           de_now,
  output logic           sof,
  output logic [HSZ-1:0] hcount,
  output logic [VSZ-1:0] vcount,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic           frame
);

  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEGIN = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEGIN = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic h_last;
  logic v_last;
  logic hs_act;
  logic vs_act;

  // Decode the current counter position; vsync depends on v only (line-aligned)
  always_comb begin
    h_last = (32'(h) == H_LAST);
    v_last = (32'(v) == V_LAST);
    de_now = (32'(h) < H_ACT) && (32'(v) < V_ACT);
    hs_act = (32'(h) >= HS_BEGIN) && (32'(h) < HS_END);
    vs_act = (32'(v) >= VS_BEGIN) && (32'(v) < VS_END);
    sof    = (h == '0) && (v == '0);
  end

  // Raster counters: h wraps at end of line, v advances on the wrap
  always_ff @(posedge clk) begin
    if (!rstn) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Timing outputs register the decode one enabled cycle behind the counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hcount <= '0;
      vcount <= '0;
      de     <= 1'b0;
      hsync  <= ~H_POL;
      vsync  <= ~V_POL;
      frame  <= 1'b0;
    end else if (ce) begin
      hcount <= h;
      vcount <= v;
      de     <= de_now;
      hsync  <= hs_act ? H_POL : ~H_POL;
      vsync  <= vs_act ? V_POL : ~V_POL;
      frame  <= sof;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Programmable video timing generator with four test patterns.
// Mode and solid colour are latched at frame start so a pattern never
// changes mid-frame; a change presented on the frame-start cycle applies
// to that same frame.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIX_SZ   = DEF_PIX_SZ,
  parameter int BAR_W    = DEF_BAR_W,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HSZ     = $clog2(H_TOTAL),
  localparam int VSZ     = $clog2(V_TOTAL)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ce_i,
  input  logic [1:0]            mode_i,
  input  logic [3*PIX_SZ-1:0]   solid_i,
  output logic [HSZ-1:0]        hcount_o,
  output logic [VSZ-1:0]        vcount_o,
  output logic                  de_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  frame_o,
  output logic [PIX_SZ-1:0]     r_o,
  output logic [PIX_SZ-1:0]     g_o,
  output logic [PIX_SZ-1:0]     b_o
);

  localparam logic [31:0] BAR_DIV = 32'(BAR_W);
  localparam logic [31:0] BAR_LIM = 32'(7 * BAR_W);

  logic [HSZ-1:0]      h;
  logic [VSZ-1:0]      v;
  logic                de_now;
  logic                sof;

  mode_e               mode_q;
  logic [3*PIX_SZ-1:0] solid_q;
  mode_e               mode_eff;
  logic [3*PIX_SZ-1:0] solid_eff;

  logic [2:0]          bar_idx;
  logic [2:0]          bar_rgb;
  logic                chk;
  logic [PIX_SZ-1:0]   grad;
  logic [PIX_SZ-1:0]   r_n;
  logic [PIX_SZ-1:0]   g_n;
  logic [PIX_SZ-1:0]   b_n;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_POL    (H_POL),
    .V_POL    (V_POL)
  ) u_timing (
    .clk    (clk_i),
    .rstn   (rstn_i),
    .ce     (ce_i),
    .h      (h),
    .v      (v),
    .de_now (de_now),
    .sof    (sof),
    .hcount (hcount_o),
    .vcount (vcount_o),
    .de     (de_o),
    .hsync  (hsync_o),
    .vsync  (vsync_o),
    .frame  (frame_o)
  );

  // Capture pattern selection on the enabled frame-start cycle
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mode_q  <= MODE_BARS;
      solid_q <= '0;
    end else if (ce_i && sof) begin
      mode_q  <= mode_e'(mode_i);
      solid_q <= solid_i;
    end
  end

  // Pixel (0,0) bypasses the latch so a new mode applies to the frame it starts
  assign mode_eff  = sof ? mode_e'(mode_i) : mode_q;
  assign solid_eff = sof ? solid_i : solid_q;

  // Gradient takes the top PIX_SZ bits of h, left-aligned when h is narrower
  if (HSZ >= PIX_SZ) begin : g_grad_slice
    assign grad = h[HSZ-1 -: PIX_SZ];
  end else begin : g_grad_pad
    assign grad = {h, {(PIX_SZ-HSZ){1'b0}}};
  end

  // Pattern mux for the current position; blanking forces black
  always_comb begin
    bar_idx = (32'(h) >= BAR_LIM) ? 3'd7 : 3'(32'(h) / BAR_DIV);
    bar_rgb = bar_flags(bar_idx);
    chk     = ((32'(h) ^ 32'(v)) & 32'h20) != 32'h0;
    r_n     = '0;
    g_n     = '0;
    b_n     = '0;
    if (de_now) begin
      case (mode_eff)
        MODE_BARS: begin
          r_n = {PIX_SZ{bar_rgb[2]}};
          g_n = {PIX_SZ{bar_rgb[1]}};
          b_n = {PIX_SZ{bar_rgb[0]}};
        end
        MODE_CHECK: begin
          r_n = {PIX_SZ{chk}};
          g_n = {PIX_SZ{chk}};
          b_n = {PIX_SZ{chk}};
        end
        MODE_GRAD: begin
          r_n = grad;
          g_n = grad;
          b_n = grad;
        end
        default: begin
          r_n = solid_eff[3*PIX_SZ-1 -: PIX_SZ];
          g_n = solid_eff[2*PIX_SZ-1 -: PIX_SZ];
          b_n = solid_eff[PIX_SZ-1:0];
        end
      endcase
    end
  end

  // Colour output registers, aligned with the registered timing outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_o <= '0;
      g_o <= '0;
      b_o <= '0;
    end else if (ce_i) begin
      r_o <= r_n;
      g_o <= g_n;
      b_o <= b_n;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: default 640x480 instance, a mid-size instance
// driven with random stimulus against a position-arithmetic model, and a tiny
// instance with active-high syncs.
module tb_video_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default-parameter instance
  logic        d_rstn, d_ce;
  logic [1:0]  d_mode;
  logic [11:0] d_solid;
  logic [9:0]  d_hc, d_vc;
  logic        d_de, d_hs, d_vs, d_fr;
  logic [3:0]  d_r, d_g, d_b;

  video_pattern_gen u_def (
    .clk_i(clk), .rstn_i(d_rstn), .ce_i(d_ce), .mode_i(d_mode), .solid_i(d_solid),
    .hcount_o(d_hc), .vcount_o(d_vc), .de_o(d_de), .hsync_o(d_hs), .vsync_o(d_vs),
    .frame_o(d_fr), .r_o(d_r), .g_o(d_g), .b_o(d_b)
  );

  // mid-size instance: 72 x 11 total, 64 x 8 active, hsync active-high
  localparam int MHT = 72;
  localparam int MVT = 11;
  localparam int MFT = MHT * MVT;
  logic        m_rstn, m_ce;
  logic [1:0]  m_mode;
  logic [11:0] m_solid;
  logic [6:0]  m_hc;
  logic [3:0]  m_vc;
  logic        m_de, m_hs, m_vs, m_fr;
  logic [3:0]  m_r, m_g, m_b;

  video_pattern_gen #(
    .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .PIX_SZ(4), .BAR_W(8)
  ) u_mid (
    .clk_i(clk), .rstn_i(m_rstn), .ce_i(m_ce), .mode_i(m_mode), .solid_i(m_solid),
    .hcount_o(m_hc), .vcount_o(m_vc), .de_o(m_de), .hsync_o(m_hs), .vsync_o(m_vs),
    .frame_o(m_fr), .r_o(m_r), .g_o(m_g), .b_o(m_b)
  );

  // tiny instance: 12 x 7 total, active-high syncs
  logic        s_rstn, s_ce;
  logic [1:0]  s_mode;
  logic [11:0] s_solid;
  logic [3:0]  s_hc;
  logic [2:0]  s_vc;
  logic        s_de, s_hs, s_vs, s_fr;
  logic [3:0]  s_r, s_g, s_b;

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_small (
    .clk_i(clk), .rstn_i(s_rstn), .ce_i(s_ce), .mode_i(s_mode), .solid_i(s_solid),
    .hcount_o(s_hc), .vcount_o(s_vc), .de_o(s_de), .hsync_o(s_hs), .vsync_o(s_vs),
    .frame_o(s_fr), .r_o(s_r), .g_o(s_g), .b_o(s_b)
  );

  // Reference bar colours, left to right
  function automatic logic [2:0] bar_ref(input int idx);
    case (idx)
      0:       return 3'b111; // white
      1:       return 3'b110; // yellow
      2:       return 3'b011; // cyan
      3:       return 3'b010; // green
      4:       return 3'b101; // magenta
      5:       return 3'b100; // red
      6:       return 3'b001; // blue
      default: return 3'b000; // black
    endcase
  endfunction

  task automatic test_reset;
    d_rstn = 1'b0; d_ce = 1'b1; d_mode = 2'd0; d_solid = 12'h000;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (d_de !== 1'b0) begin errors++; $display("FAIL reset_de got %b exp 0", d_de); end
    checks++;
    if ({d_hs, d_vs} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b exp 11", {d_hs, d_vs}); end
    checks++;
    if ({d_r, d_g, d_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", {d_r, d_g, d_b}); end
    checks++;
    if ({d_hc, d_vc, d_fr} !== 21'd0) begin errors++; $display("FAIL reset_count got h=%0d v=%0d f=%b exp 0 0 0", d_hc, d_vc, d_fr); end
  endtask

  task automatic test_default_line;
    int falls[2];
    int nf, lowcnt, vslow;
    logic prev_hs;
    logic [12:0] exp_px;
    falls[0] = -1; falls[1] = -1; nf = 0; lowcnt = 0; vslow = 0; prev_hs = 1'b1;
    @(negedge clk);
    d_rstn = 1'b1; d_ce = 1'b1; d_mode = 2'd0;
    for (int k = 0; k < 1800; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({d_hc, d_vc, d_fr} !== {10'(k % 800), 10'(k / 800), (k == 0)}) begin
        errors++;
        $display("FAIL def_pos k=%0d got h=%0d v=%0d f=%b exp h=%0d v=%0d f=%b",
                 k, d_hc, d_vc, d_fr, k % 800, k / 800, (k == 0));
      end
      exp_px = 13'h1fff;
      case (k)
        0:   exp_px = {1'b1, 12'hFFF};
        80:  exp_px = {1'b1, 12'hFF0};
        559: exp_px = {1'b1, 12'h00F};
        560: exp_px = {1'b1, 12'h000};
        639: exp_px = {1'b1, 12'h000};
        640: exp_px = {1'b0, 12'h000};
        default: ;
      endcase
      if (exp_px != 13'h1fff) begin
        checks++;
        if ({d_de, d_r, d_g, d_b} !== exp_px) begin
          errors++;
          $display("FAIL bars_h%0d got de=%b rgb=%h exp de=%b rgb=%h",
                   k, d_de, {d_r, d_g, d_b}, exp_px[12], exp_px[11:0]);
        end
      end
      if (prev_hs && !d_hs && nf < 2) begin falls[nf] = k; nf++; end
      if (!d_hs && k < 800) lowcnt++;
      if (!d_vs) vslow++;
      prev_hs = d_hs;
    end
    checks++;
    if (falls[0] != 656) begin errors++; $display("FAIL hsync_start got %0d exp 656", falls[0]); end
    checks++;
    if (falls[1] - falls[0] != 800) begin errors++; $display("FAIL hsync_period got %0d exp 800", falls[1] - falls[0]); end
    checks++;
    if (lowcnt != 96) begin errors++; $display("FAIL hsync_width got %0d exp 96", lowcnt); end
    checks++;
    if (vslow != 0) begin errors++; $display("FAIL vsync_early got %0d low cycles exp 0", vslow); end
  endtask

  task automatic test_ce;
    logic [36:0] cur, prev;
    int unstable, frcnt, nf;
    int falls[2];
    logic prev_hs;
    unstable = 0; frcnt = 0; nf = 0; falls[0] = -1; falls[1] = -1; prev_hs = 1'b1; prev = '0;
    @(negedge clk);
    d_rstn = 1'b0; d_ce = 1'b1; d_mode = 2'd0;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 4500; c++) begin
      @(negedge clk);
      d_rstn = 1'b1;
      d_ce = (c % 3 == 0);
      @(posedge clk);
      #1;
      cur = {d_hc, d_vc, d_de, d_hs, d_vs, d_fr, d_r, d_g, d_b};
      if (!d_ce && cur !== prev) unstable++;
      if (c < 9 && d_fr) frcnt++;
      if (prev_hs && !d_hs && nf < 2) begin falls[nf] = c; nf++; end
      prev_hs = d_hs;
      prev = cur;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL ce_hold got %0d changes on low-ce cycles exp 0", unstable); end
    checks++;
    if (frcnt != 3) begin errors++; $display("FAIL ce_frame_span got %0d exp 3", frcnt); end
    checks++;
    if (falls[0] != 1968) begin errors++; $display("FAIL ce_hsync_start got %0d exp 1968", falls[0]); end
    checks++;
    if (falls[1] - falls[0] != 2400) begin errors++; $display("FAIL ce_line_period got %0d exp 2400", falls[1] - falls[0]); end
    d_ce = 1'b1;
  endtask

  task automatic test_small;
    int eh, ev, nfr, rises[2], nr;
    logic ede, ehs, evs, efr, prev_hs;
    nfr = 0; nr = 0; rises[0] = -1; rises[1] = -1; prev_hs = 1'b0;
    @(negedge clk);
    s_rstn = 1'b0; s_ce = 1'b1; s_mode = 2'd0; s_solid = 12'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rstn = 1'b1;
    for (int k = 0; k < 180; k++) begin
      @(posedge clk);
      #1;
      eh = k % 12; ev = (k / 12) % 7;
      ede = (eh < 8) && (ev < 4);
      ehs = (eh == 9) || (eh == 10);
      evs = (ev == 5);
      efr = (k % 84 == 0);
      checks++;
      if ({s_hc, s_vc, s_de, s_hs, s_vs, s_fr} !== {4'(eh), 3'(ev), ede, ehs, evs, efr}) begin
        errors++;
        $display("FAIL small_timing k=%0d got h=%0d v=%0d de=%b hs=%b vs=%b f=%b exp h=%0d v=%0d de=%b hs=%b vs=%b f=%b",
                 k, s_hc, s_vc, s_de, s_hs, s_vs, s_fr, eh, ev, ede, ehs, evs, efr);
      end
      if (s_fr) nfr++;
      if (!prev_hs && s_hs && nr < 2) begin rises[nr] = k; nr++; end
      prev_hs = s_hs;
    end
    checks++;
    if (nfr != 3) begin errors++; $display("FAIL small_frames got %0d exp 3", nfr); end
    checks++;
    if (rises[1] - rises[0] != 12) begin errors++; $display("FAIL small_line got %0d exp 12", rises[1] - rises[0]); end
    // reset in the middle of a frame, release with ce low first
    @(negedge clk); s_rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); s_rstn = 1'b1; s_ce = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_hc, s_vc, s_fr, s_hs} !== {4'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL small_rst_hold got h=%0d v=%0d f=%b hs=%b exp 0 0 0 0", s_hc, s_vc, s_fr, s_hs);
    end
    @(negedge clk); s_ce = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_hc, s_vc, s_fr, s_de} !== {4'd0, 3'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL small_rst_first got h=%0d v=%0d f=%b de=%b exp 0 0 1 1", s_hc, s_vc, s_fr, s_de);
    end
    @(posedge clk); #1;
    checks++;
    if ({s_hc, s_fr} !== {4'd1, 1'b0}) begin
      errors++; $display("FAIL small_rst_next got h=%0d f=%b exp 1 0", s_hc, s_fr);
    end
  endtask

  task automatic test_mode_latch;
    int h, v, bad1, bad2;
    logic [2:0] f;
    bad1 = 0; bad2 = 0;
    @(negedge clk);
    m_rstn = 1'b0; m_ce = 1'b1; m_mode = 2'd0; m_solid = 12'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_rstn = 1'b1;
    for (int k = 0; k < 2 * MFT; k++) begin
      @(posedge clk);
      #1;
      h = k % MHT; v = (k / MHT) % MVT;
      if (h < 64 && v < 8) begin
        if (k < MFT) begin
          f = bar_ref(h / 8);
          if ({m_r, m_g, m_b} !== {{4{f[2]}}, {4{f[1]}}, {4{f[0]}}}) bad1++;
        end else begin
          if ({m_r, m_g, m_b} !== 12'hA5C) bad2++;
        end
      end
      @(negedge clk);
      if (k == 3 * MHT - 1) begin m_mode = 2'd3; m_solid = 12'hA5C; end
    end
    checks++;
    if (bad1 != 0) begin errors++; $display("FAIL latch_same_frame got %0d non-bar pixels exp 0", bad1); end
    checks++;
    if (bad2 != 0) begin errors++; $display("FAIL latch_next_frame got %0d non-A5C pixels exp 0", bad2); end
  endtask

  task automatic test_random;
    int n, p, h, v, nerr;
    logic [1:0] lm;
    logic [11:0] ls;
    logic ede, ehs, evs, efr, chk;
    logic [2:0] f;
    logic [3:0] er, eg, eb;
    logic [26:0] expv, actv;
    logic chg;
    n = 0; lm = 2'd0; ls = 12'h000; nerr = 0;
    for (int c = 0; c < 7000; c++) begin
      @(negedge clk);
      m_rstn = (c < 3) ? 1'b0 : ($urandom_range(0, 2999) != 0);
      m_ce = ($urandom_range(0, 3) != 0);
      chg = (n % MFT == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 63) == 0);
      if (chg) begin
        m_mode = 2'($urandom_range(0, 3));
        m_solid = 12'($urandom);
      end
      @(posedge clk);
      if (!m_rstn) n = 0;
      else if (m_ce) begin
        if (n % MFT == 0) begin lm = m_mode; ls = m_solid; end
        n++;
      end
      #1;
      if (n == 0) begin
        expv = {7'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
      end else begin
        p = n - 1;
        h = p % MHT;
        v = (p / MHT) % MVT;
        ede = (h < 64) && (v < 8);
        ehs = (h >= 66) && (h < 70);
        evs = (v != 9);
        efr = (p % MFT == 0);
        er = 4'h0; eg = 4'h0; eb = 4'h0;
        if (ede) begin
          case (lm)
            2'd0: begin
              f = bar_ref(h / 8);
              er = {4{f[2]}}; eg = {4{f[1]}}; eb = {4{f[0]}};
            end
            2'd1: begin
              chk = ((h / 32) % 2) != ((v / 32) % 2);
              er = {4{chk}}; eg = {4{chk}}; eb = {4{chk}};
            end
            2'd2: begin
              er = 4'(h / 8); eg = 4'(h / 8); eb = 4'(h / 8);
            end
            default: begin
              er = ls[11:8]; eg = ls[7:4]; eb = ls[3:0];
            end
          endcase
        end
        expv = {7'(h), 4'(v), ede, ehs, evs, efr, er, eg, eb};
      end
      actv = {m_hc, m_vc, m_de, m_hs, m_vs, m_fr, m_r, m_g, m_b};
      checks++;
      if (actv !== expv) begin
        errors++;
        nerr++;
        if (nerr <= 10)
          $display("FAIL random c=%0d got %h exp %h (h,v,de,hs,vs,f,rgb)", c, actv, expv);
      end
    end
  endtask

  initial begin
    d_rstn = 1'b0; d_ce = 1'b0; d_mode = 2'd0; d_solid = 12'h000;
    m_rstn = 1'b0; m_ce = 1'b0; m_mode = 2'd0; m_solid = 12'h000;
    s_rstn = 1'b0; s_ce = 1'b0; s_mode = 2'd0; s_solid = 12'h000;
    test_reset();
    test_default_line();
    test_ce();
    test_small();
    test_mode_latch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no completion exp finish");
    $fatal(1, "timeout");
  end

endmodule
